ctrl_pipe: RTL and testbench

- Pipelined successor to the ID-stage decoder. Takes the decoded control word plus register fields from ID and carries them through EX, MEM and WB.
- Detects load-use and HI/LO multiply/divide hazards, and raises the stall signals for IF and ID.
- Inserts bubbles on stall or flush, and tracks a multi-cycle MDU busy window.
- Sits between the combinational decoder and the pipeline registers.

---
 rtl/ctrl_pkg.sv | 25 ++
 rtl/ctrl_pipe_mdu_busy_ctr.sv | 25 ++
 rtl/ctrl_pipe.sv | 114 +++++++++++
 tb/tb_ctrl_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-pipe types: control-word bit positions, forward selects, stage record.
package ctrl_pkg;
  localparam int DP_REGWRITE_BIT = 1;
  localparam int DP_MEMREAD_BIT  = 6;
  localparam int CP_DP_W         = 16;
  localparam int CP_REG_AW       = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                 valid;
    logic [CP_DP_W-1:0]   dp;
    logic [CP_REG_AW-1:0] dst;
  } stage_t;

  // qual carries stage-valid & the relevant dp bit; $0 never matches
  function automatic logic src_hit(logic qual, logic [CP_REG_AW-1:0] dst,
                                   logic use_src, logic [CP_REG_AW-1:0] src);
    return qual & use_src & (dst != '0) & (src == dst);
  endfunction
endpackage

// File: rtl/ctrl_pipe_mdu_busy_ctr.sv
// HI/LO occupancy down-counter: loads the op latency-1, counts to zero.
module mdu_busy_ctr #(
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] lat_i,
  output logic             busy_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)            cnt_d = lat_i;
    else if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipe with load-use, HI/LO and RAW stall generation.
// Define CTRL_FWD_EN to add fwd_a/fwd_b bypass selects and drop RAW stalls.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int DP_W    = CP_DP_W,
  parameter int REG_AW  = CP_REG_AW,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [DP_W-1:0]   id_dp,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_hilo_rd,
  input  logic              id_mdu_start,
  input  logic              id_mdu_div,
  input  logic              flush,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [DP_W-1:0]   ex_dp,
  output logic [DP_W-1:0]   mem_dp,
  output logic [DP_W-1:0]   wb_dp,
  output logic [REG_AW-1:0] ex_dst,
  output logic [REG_AW-1:0] mem_dst,
  output logic [REG_AW-1:0] wb_dst,
  output logic              if_stall,
  output logic              id_stall,
  output logic              mdu_busy
`ifdef CTRL_FWD_EN
  ,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`endif
);
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  stage_t ex_q, mem_q, wb_q, ex_d;
  logic lu_haz, mdu_haz, raw_haz, accept;
  logic [CNT_W-1:0] mdu_lat;

  always_comb begin
    lu_haz  = ex_q.valid & ex_q.dp[DP_MEMREAD_BIT] & (ex_q.dst != '0) &
              ((id_uses_rs & (id_rs == ex_q.dst)) | (id_uses_rt & (id_rt == ex_q.dst)));
    mdu_haz = id_valid & (id_hilo_rd | id_mdu_start) & mdu_busy;
`ifdef CTRL_FWD_EN
    raw_haz = 1'b0;
`else
    // no bypass: any in-flight writer of a source holds ID until it retires
    raw_haz = 1'b0;
    for (int s = 0; s < 3; s++) begin
      stage_t st;
      st = (s == 0) ? ex_q : (s == 1) ? mem_q : wb_q;
      raw_haz |= src_hit(st.valid & st.dp[DP_REGWRITE_BIT], st.dst, id_uses_rs, id_rs) |
                 src_hit(st.valid & st.dp[DP_REGWRITE_BIT], st.dst, id_uses_rt, id_rt);
    end
`endif
    id_stall = ~flush & (lu_haz | mdu_haz | raw_haz);
    if_stall = id_stall;
    accept   = id_valid & ~id_stall & ~flush;
    ex_d     = '0;
    if (accept) ex_d = '{valid: 1'b1, dp: id_dp, dst: id_dst};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign mdu_lat = id_mdu_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

  mdu_busy_ctr #(.CNT_W(CNT_W)) u_mdu (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (accept & id_mdu_start),
    .lat_i   (mdu_lat),
    .busy_o  (mdu_busy)
  );

  assign ex_valid  = ex_q.valid;
  assign mem_valid = mem_q.valid;
  assign wb_valid  = wb_q.valid;
  assign ex_dp     = ex_q.dp;
  assign mem_dp    = mem_q.dp;
  assign wb_dp     = wb_q.dp;
  assign ex_dst    = ex_q.dst;
  assign mem_dst   = mem_q.dst;
  assign wb_dst    = wb_q.dst;

`ifdef CTRL_FWD_EN
  function automatic fwd_sel_e fwd_pick(logic [REG_AW-1:0] src);
    if (src_hit(mem_q.valid & mem_q.dp[DP_REGWRITE_BIT], mem_q.dst, 1'b1, src)) return FWD_MEM;
    if (src_hit(wb_q.valid & wb_q.dp[DP_REGWRITE_BIT], wb_q.dst, 1'b1, src))    return FWD_WB;
    return FWD_RF;
  endfunction

  assign fwd_a = fwd_pick(id_rs);
  assign fwd_b = fwd_pick(id_rt);
`endif
endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized + directed bench for ctrl_pipe against a cycle-level behavioural model.
module tb_ctrl_pipe;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic        clock = 1'b0;
  logic        reset_n, id_valid, id_uses_rs, id_uses_rt, id_hilo_rd, id_mdu_start, id_mdu_div, flush;
  logic [15:0] id_dp;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        ex_valid, mem_valid, wb_valid, if_stall, id_stall, mdu_busy;
  logic [15:0] ex_dp, mem_dp, wb_dp;
  logic [4:0]  ex_dst, mem_dst, wb_dst;
`ifdef CTRL_FWD_EN
  logic [1:0]  fwd_a, fwd_b;
`endif

  ctrl_pipe dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_dp(id_dp),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_hilo_rd(id_hilo_rd), .id_mdu_start(id_mdu_start),
    .id_mdu_div(id_mdu_div), .flush(flush),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_dp(ex_dp), .mem_dp(mem_dp), .wb_dp(wb_dp),
    .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .if_stall(if_stall), .id_stall(id_stall), .mdu_busy(mdu_busy)
`ifdef CTRL_FWD_EN
    , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // model: m[0]=EX, m[1]=MEM, m[2]=WB; mcnt = HI/LO cycles still owed
  typedef struct { bit v; logic [15:0] dp; logic [4:0] dst; } mst_t;
  mst_t m[3];
  int   mcnt;
  bit   exp_stall, obs_stall;
  logic [1:0] obs_fwd_a;

  function automatic bit writes_to(mst_t s, logic [4:0] r);
    return s.v && s.dp[1] && s.dst != 0 && s.dst == r;
  endfunction

  function automatic logic [1:0] exp_fwd(logic [4:0] r);
    if (writes_to(m[1], r)) return 2'b01;
    if (writes_to(m[2], r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) m[i] = '{v: 1'b0, dp: 16'h0, dst: 5'h0};
    mcnt = 0;
  endtask

  // inputs already driven; check this cycle, clock, advance the model
  task automatic step();
    bit lu, mh, raw, acc;
    #1;
    lu  = m[0].v && m[0].dp[6] && m[0].dst != 0 &&
          ((id_uses_rs && id_rs == m[0].dst) || (id_uses_rt && id_rt == m[0].dst));
    mh  = id_valid && (id_hilo_rd || id_mdu_start) && mcnt != 0;
    raw = 1'b0;
`ifndef CTRL_FWD_EN
    for (int i = 0; i < 3; i++)
      if ((id_uses_rs && writes_to(m[i], id_rs)) || (id_uses_rt && writes_to(m[i], id_rt))) raw = 1'b1;
`endif
    exp_stall = !flush && (lu || mh || raw);
    obs_stall = id_stall;
    chk("ex",  {ex_valid, ex_dp, ex_dst},    {m[0].v, m[0].dp, m[0].dst});
    chk("mem", {mem_valid, mem_dp, mem_dst}, {m[1].v, m[1].dp, m[1].dst});
    chk("wb",  {wb_valid, wb_dp, wb_dst},    {m[2].v, m[2].dp, m[2].dst});
    chk("id_stall", id_stall, exp_stall);
    chk("if_stall", if_stall, exp_stall);
    chk("mdu_busy", mdu_busy, mcnt != 0);
`ifdef CTRL_FWD_EN
    obs_fwd_a = fwd_a;
    chk("fwd_a", fwd_a, exp_fwd(id_rs));
    chk("fwd_b", fwd_b, exp_fwd(id_rt));
`else
    obs_fwd_a = 2'b00;
`endif
    @(posedge clock);
    if (!reset_n) model_clear();
    else begin
      acc  = id_valid && !exp_stall && !flush;
      m[2] = m[1];
      m[1] = m[0];
      m[0] = acc ? '{v: 1'b1, dp: id_dp, dst: id_dst} : '{v: 1'b0, dp: 16'h0, dst: 5'h0};
      if (acc && id_mdu_start) mcnt = id_mdu_div ? DIV_LAT - 1 : MUL_LAT - 1;
      else if (mcnt > 0)       mcnt--;
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_dp = 0; id_rs = 0; id_rt = 0; id_dst = 0; id_uses_rs = 0;
    id_uses_rt = 0; id_hilo_rd = 0; id_mdu_start = 0; id_mdu_div = 0; flush = 0;
  endtask

  task automatic drain(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  // hold one instruction in ID until the DUT accepts it; returns stall cycles seen
  task automatic issue(input logic [15:0] dp, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input bit ur, input bit ut, input bit hl,
                       input bit ms, input bit dv, output int stalls);
    id_valid = 1; id_dp = dp; id_rs = rs; id_rt = rt; id_dst = dst; id_uses_rs = ur;
    id_uses_rt = ut; id_hilo_rd = hl; id_mdu_start = ms; id_mdu_div = dv; flush = 0;
    stalls = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (!obs_stall) break;
      stalls++;
    end
    if (stalls >= 100) chk("accept_timeout", stalls, 0);
    chk("accept_ex_dp", {ex_valid, ex_dp}, {1'b1, dp});
    idle();
  endtask

  initial begin
    int s;
    logic [1:0] fwd_seen;
    idle();
    reset_n = 0;
    @(posedge clock); #1;
    model_clear();
    step();
    chk("rst_valids", {ex_valid, mem_valid, wb_valid}, 3'b000);
    chk("rst_dp", {ex_dp, mem_dp, wb_dp}, 48'h0);
    chk("rst_busy", mdu_busy, 1'b0);
    reset_n = 1;
    drain(1);

    // load-use: lw r8 then add r8
    issue(16'h0042, 5'd0, 5'd0, 5'd8, 0, 0, 0, 0, 0, s);
    issue(16'h0002, 5'd8, 5'd9, 5'd10, 1, 1, 0, 0, 0, s);
`ifdef CTRL_FWD_EN
    chk("loaduse_stalls", s, 1);
`else
    chk("loaduse_stalls", s, 3);
`endif
    drain(4);

    // div then mflo; mult then mflo
    issue(16'h0000, 5'd1, 5'd2, 5'd0, 1, 1, 0, 1, 1, s);
    issue(16'h0002, 5'd0, 5'd0, 5'd11, 0, 0, 1, 0, 0, s);
    chk("div_stalls", s, DIV_LAT - 1);
    chk("div_busy_done", mdu_busy, 1'b0);
    drain(4);
    issue(16'h0000, 5'd1, 5'd2, 5'd0, 1, 1, 0, 1, 0, s);
    issue(16'h0002, 5'd0, 5'd0, 5'd11, 0, 0, 1, 0, 0, s);
    chk("mul_stalls", s, MUL_LAT - 1);
    drain(4);

    // load to $0 then reader of $0
    issue(16'h0042, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, s);
    issue(16'h0002, 5'd0, 5'd0, 5'd12, 1, 1, 0, 0, 0, s);
    chk("r0_stalls", s, 0);
    drain(4);

    // flush wins over a load-use stall
    issue(16'h0042, 5'd0, 5'd0, 5'd8, 0, 0, 0, 0, 0, s);
    id_valid = 1; id_dp = 16'h0002; id_rs = 5'd8; id_uses_rs = 1; id_dst = 5'd10; flush = 1;
    step();
    chk("flush_stall", obs_stall, 1'b0);
    chk("flush_bubble", ex_valid, 1'b0);
    idle();
    issue(16'h0002, 5'd12, 5'd0, 5'd13, 1, 0, 0, 0, 0, s);
    chk("after_flush_stalls", s, 0);
    drain(4);

    // r3 in MEM and WB, consumer reads r3
    issue(16'h0002, 5'd0, 5'd0, 5'd3, 0, 0, 0, 0, 0, s);
    issue(16'h0006, 5'd0, 5'd0, 5'd3, 0, 0, 0, 0, 0, s);
    drain(1);
    issue(16'h0002, 5'd3, 5'd0, 5'd4, 1, 0, 0, 0, 0, s);
    fwd_seen = obs_fwd_a;
`ifdef CTRL_FWD_EN
    chk("fwd_stalls", s, 0);
    chk("fwd_a_mem", fwd_seen, 2'b01);
`else
    chk("raw_stalls", s, 2);
`endif
    drain(4);

    // reset mid-divide
    issue(16'h0000, 5'd1, 5'd2, 5'd0, 1, 1, 0, 1, 1, s);
    drain(3);
    reset_n = 0;
    step();
    reset_n = 1;
    chk("rst_div_busy", mdu_busy, 1'b0);
    chk("rst_div_valids", {ex_valid, mem_valid, wb_valid}, 3'b000);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset_n      = ($urandom_range(0, 499) != 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_dp        = 16'($urandom);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_dst       = 5'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      id_hilo_rd   = ($urandom_range(0, 7) == 0);
      id_mdu_start = ($urandom_range(0, 23) == 0);
      id_mdu_div   = 1'($urandom_range(0, 1));
      flush        = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
